// File: rtl/comp_serial_nb_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
package comp_defs;

  // Default operand width.
  localparam int COMP_W_DEF = 8;

  // Controller state encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/comp_serial_nb_if.sv
// Request/result bundle between a client and comp_serial_nb.
interface comp_serial_nb_if
  import comp_defs::*;
#(
  parameter int N = COMP_W_DEF
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;

  modport master (output start, a, b, input busy, done, eq, gt, lt);
  modport slave  (input start, a, b, output busy, done, eq, gt, lt);

endinterface

// File: rtl/comp_1b.sv
// 1-bit equality comparator.
module comp_1b (
  input  logic i0,
  input  logic i1,
  output logic eq
);

  assign eq = ~(i0 ^ i1);

endmodule

// File: rtl/comp_serial_nb.sv
// Bit-serial N-bit unsigned magnitude comparator. Operands are captured on
// start and streamed MSB-first through comp_1b; the first differing bit pair
// decides the result, which is held until the next completion.
module comp_serial_nb
  import comp_defs::*;
#(
  parameter int N = COMP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  comp_serial_nb_if.slave   bus
);

  localparam int CW = $clog2(N);

  logic [0:0]    state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [CW-1:0] cnt;
  logic          dec;
  logic          acc_gt;

  logic          bit_eq;
  logic          dec_final;
  logic          gt_final;

  comp_1b u_comp_1b (
    .i0 (sa[N-1]),
    .i1 (sb[N-1]),
    .eq (bit_eq)
  );

  // Decision including the bit pair currently presented to comp_1b; used on
  // the last bit so the final edge folds in the LSB comparison.
  always_comb begin
    dec_final = dec | ~bit_eq;
    gt_final  = dec ? acc_gt : sa[N-1];
  end

  // Controller, operand shifters and result registers.
  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge values of sa/sb/dec/cnt regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      dec      <= 1'b0;
      acc_gt   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.eq   <= 1'b0;
      bus.gt   <= 1'b0;
      bus.lt   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.start) begin
          sa       <= bus.a;
          sb       <= bus.b;
          cnt      <= CW'(N - 1);
          dec      <= 1'b0;
          acc_gt   <= 1'b0;
          bus.busy <= 1'b1;
          state    <= ST_SHIFT;
        end
      end else begin
        if (!dec && !bit_eq) begin
          dec    <= 1'b1;
          acc_gt <= sa[N-1];
        end
        sa <= {sa[N-2:0], 1'b0};
        sb <= {sb[N-2:0], 1'b0};
        if (cnt == '0) begin
          bus.eq   <= ~dec_final;
          bus.gt   <= dec_final & gt_final;
          bus.lt   <= dec_final & ~gt_final;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_comp_serial_nb.sv
// Directed bench for comp_serial_nb with a cycle-level reference model.
module tb_comp_serial_nb;
  import comp_defs::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comp_serial_nb_if #(.N(N)) bus ();

  comp_serial_nb #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation accepted while idle completes N edges later
  // with the plain arithmetic comparison of the captured operands.
  logic [N-1:0] m_a, m_b;
  int           m_left;
  logic         m_busy, m_done, m_eq, m_gt, m_lt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_left <= 0;
      m_busy <= 1'b0; m_done <= 1'b0;
      m_eq <= 1'b0; m_gt <= 1'b0; m_lt <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_eq   <= (m_a == m_b);
          m_gt   <= (m_a >  m_b);
          m_lt   <= (m_a <  m_b);
        end
      end else if (bus.start) begin
        m_a    <= bus.a;
        m_b    <= bus.b;
        m_left <= N;
        m_busy <= 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en)
      check("model_cmp", {27'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt},
                         {27'd0, m_busy, m_done, m_eq, m_gt, m_lt});
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [N-1:0] av, input logic [N-1:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; returns on the done negedge with busy count.
  task automatic wait_done(input string name, output int bc);
    bit got;
    got = 1'b0;
    bc  = 0;
    for (int i = 0; i < 4 * N; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) bc++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
  endtask

  function automatic logic [31:0] res();
    return {29'd0, bus.eq, bus.gt, bus.lt};
  endfunction

  initial begin
    int bc;
    int dcount;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {27'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // 1: equal operands, full-length busy window
    do_start(8'hA5, 8'hA5);
    wait_done("t1", bc);
    check("t1_busy_cycles", 32'(bc), 32'd8);
    check("t1_busy_low_at_done", 32'(bus.busy), 32'd0);
    check("t1_result", res(), 32'b100);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(bus.done), 32'd0);

    // 2: decided at MSB, still takes all N edges
    do_start(8'h80, 8'h7F);
    wait_done("t2", bc);
    check("t2_busy_cycles", 32'(bc), 32'd8);
    check("t2_result", res(), 32'b010);
    @(negedge clk);

    // 3: decided at bit 1, result held through idle time
    do_start(8'h01, 8'h02);
    wait_done("t3", bc);
    check("t3_result", res(), 32'b001);
    repeat (20) @(negedge clk);
    check("t3_result_held", res(), 32'b001);

    // 4: start while busy ignored, operand change after capture ignored
    do_start(8'h10, 8'h10);
    @(negedge clk);
    @(negedge clk);
    bus.a     = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) dcount++;
      @(negedge clk);
    end
    check("t4_single_done", 32'(dcount), 32'd1);
    check("t4_result", res(), 32'b100);

    // 5: asynchronous reset mid-operation, then a normal operation
    do_start(8'h33, 8'h44);
    repeat (3) @(negedge clk);
    check("t5_busy_before_rst", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("t5_async_clear", {27'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_no_done_after_abort", 32'(bus.done), 32'd0);
    do_start(8'h44, 8'h33);
    wait_done("t5", bc);
    check("t5_busy_cycles", 32'(bc), 32'd8);
    check("t5_result", res(), 32'b010);
    @(negedge clk);

    // 6: start held through the done cycle -> back-to-back acceptance
    bus.a     = 8'hC0;
    bus.b     = 8'h0C;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 8'h00;
    bus.b = 8'hFF;
    bc = 0;
    for (int i = 0; i < 4 * N; i++) begin
      if (bus.done) break;
      bc++;
      @(negedge clk);
    end
    check("t6a_done_seen", 32'(bus.done), 32'd1);
    check("t6a_result", res(), 32'b010);
    @(negedge clk);
    bus.start = 1'b0;
    check("t6b_accepted", {30'd0, bus.busy, bus.done}, 32'b10);
    check("t6b_first_result_held", res(), 32'b010);
    wait_done("t6b", bc);
    check("t6b_busy_cycles", 32'(bc), 32'd8);
    check("t6b_result", res(), 32'b001);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
